// File: rtl/video_crop_window.sv
// video_crop_window
//   Crops a fixed H_OUT x V_OUT window, starting at (H_START, V_START), out of
//   a camera pixel stream and forwards it with a fixed two-cycle latency.
//   Frames are only forwarded once a complete vsync low pulse has been seen,
//   so a partial frame after reset never reaches the frame buffer.
//
// Ports
//   I_pxl_clk   : pixel clock, all logic on its rising edge
//   I_rst       : synchronous active-high reset
//   I_vs_n      : camera vsync, low = sync
//   I_de        : input pixel valid
//   I_data      : input pixel
//   O_vs_n      : I_vs_n delayed two cycles
//   O_de        : cropped pixel valid (two cycles after the input pixel)
//   O_data      : cropped pixel, holds its last value while O_de = 0
//   O_frame_cnt : number of completed vsync pulses, wraps at 16 bits
//   O_line_len  : pixel count of the last finished input line
//   O_short_err : sticky flag, a line inside the window ended too early
module video_crop_window #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned H_START = 0,
  parameter int unsigned V_START = 0,
  parameter int unsigned H_OUT   = 1280,
  parameter int unsigned V_OUT   = 720
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst,
  input  logic              I_vs_n,
  input  logic              I_de,
  input  logic [DATA_W-1:0] I_data,
  output logic              O_vs_n,
  output logic              O_de,
  output logic [DATA_W-1:0] O_data,
  output logic [15:0]       O_frame_cnt,
  output logic [11:0]       O_line_len,
  output logic              O_short_err
);

  localparam logic [11:0] H_LO  = 12'(H_START);
  localparam logic [11:0] H_LEN = 12'(H_OUT);
  localparam logic [11:0] H_HI  = 12'(H_START + H_OUT);
  localparam logic [11:0] V_LO  = 12'(V_START);
  localparam logic [11:0] V_LEN = 12'(V_OUT);

  typedef enum logic [1:0] {
    WAIT_VS,
    IN_VS,
    ACTIVE
  } state_t;

  state_t              state_q, state_d;
  logic [11:0]         x_q, x_d;
  logic [11:0]         y_q, y_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [11:0]         line_len_q, line_len_d;
  logic                short_err_q, short_err_d;
  logic                vs_q, de_q;
  logic                keep_d, keep_q;
  logic [DATA_W-1:0]   data_q;

  logic                vs_fall, vs_rise, de_fall;
  logic [11:0]         dx, dy;
  logic                in_h, in_v;

  assign vs_fall = vs_q & ~I_vs_n;
  assign vs_rise = ~vs_q & I_vs_n;
  assign de_fall = de_q & ~I_de;

  // Offset compare: when x < start the 12-bit difference wraps above any
  // supported window length, so one unsigned compare covers both bounds.
  assign dx   = x_q - H_LO;
  assign dy   = y_q - V_LO;
  assign in_h = dx < H_LEN;
  assign in_v = dy < V_LEN;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    line_len_d  = line_len_q;
    short_err_d = short_err_q;
    keep_d      = 1'b0;
    unique case (state_q)
      WAIT_VS: begin
        if (vs_fall) begin
          state_d     = IN_VS;
          short_err_d = 1'b0;
        end
      end
      IN_VS: begin
        if (vs_rise) begin
          state_d     = ACTIVE;
          x_d         = '0;
          y_d         = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      ACTIVE: begin
        // vsync wins over pixel/line-end handling: a line cut by vsync is
        // dropped without updating the line length or error flag.
        if (vs_fall) begin
          state_d     = IN_VS;
          short_err_d = 1'b0;
        end else if (I_de) begin
          keep_d = in_h & in_v;
          if (x_q != '1) x_d = x_q + 12'd1;
        end else if (de_fall) begin
          line_len_d = x_q;
          x_d        = '0;
          if (y_q != '1) y_d = y_q + 12'd1;
          if (in_v && (x_q < H_HI)) short_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge I_pxl_clk) begin
    if (I_rst) begin
      state_q     <= WAIT_VS;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      line_len_q  <= '0;
      short_err_q <= 1'b0;
      vs_q        <= 1'b1;
      de_q        <= 1'b0;
      keep_q      <= 1'b0;
      data_q      <= '0;
      O_de        <= 1'b0;
      O_data      <= '0;
      O_vs_n      <= 1'b1;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      line_len_q  <= line_len_d;
      short_err_q <= short_err_d;
      vs_q        <= I_vs_n;
      de_q        <= I_de;
      keep_q      <= keep_d;
      if (keep_d) data_q <= I_data;
      O_de        <= keep_q;
      if (keep_q) O_data <= data_q;
      O_vs_n      <= vs_q;
    end
  end

  assign O_frame_cnt = frame_cnt_q;
  assign O_line_len  = line_len_q;
  assign O_short_err = short_err_q;

endmodule

// File: tb/tb_video_crop_window.sv
// Testbench for video_crop_window with a 4x2 window at (2,1).
// The expected-output model works per line and per vsync pulse: a line task
// knows which of its pixels fall in the window and queues them with the
// cycle they must appear on; a compare process checks every cycle.
module tb_video_crop_window;

  localparam int HS  = 2;
  localparam int VS0 = 1;
  localparam int HO  = 4;
  localparam int VO  = 2;

  logic        I_pxl_clk = 1'b0;
  logic        I_rst     = 1'b1;
  logic        I_vs_n    = 1'b1;
  logic        I_de      = 1'b0;
  logic [15:0] I_data    = '0;
  logic        O_vs_n;
  logic        O_de;
  logic [15:0] O_data;
  logic [15:0] O_frame_cnt;
  logic [11:0] O_line_len;
  logic        O_short_err;

  video_crop_window #(
    .DATA_W (16),
    .H_START(HS),
    .V_START(VS0),
    .H_OUT  (HO),
    .V_OUT  (VO)
  ) dut (
    .I_pxl_clk  (I_pxl_clk),
    .I_rst      (I_rst),
    .I_vs_n     (I_vs_n),
    .I_de       (I_de),
    .I_data     (I_data),
    .O_vs_n     (O_vs_n),
    .O_de       (O_de),
    .O_data     (O_data),
    .O_frame_cnt(O_frame_cnt),
    .O_line_len (O_line_len),
    .O_short_err(O_short_err)
  );

  always #5 I_pxl_clk = ~I_pxl_clk;

  typedef struct {
    int          t;
    logic [15:0] d;
  } exp_t;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  bit          run      = 1'b0;
  logic [1:0]  vsh      = 2'b11;
  exp_t        q[$];
  logic [15:0] obs[$];

  // model state
  bit          m_vs_prev = 1'b1;
  bit          m_insync  = 1'b0;
  bit          m_active  = 1'b0;
  int          m_y       = 0;
  int          m_frame   = 0;
  int          m_len     = 0;
  bit          m_short   = 1'b0;
  logic [15:0] m_last    = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // O_vs_n is the input vsync two clocks later
  always @(posedge I_pxl_clk) begin
    cyc <= cyc + 1;
    if (I_rst) vsh <= 2'b11;
    else       vsh <= {vsh[0], I_vs_n};
  end

  always @(negedge I_pxl_clk) begin
    bit ed;
    if (run) begin
      ed = (q.size() > 0) && (q[0].t == cyc);
      check("o_vs_n", O_vs_n, vsh[1]);
      check("o_de", O_de, ed);
      if (ed) begin
        check("o_data", O_data, q[0].d);
        m_last = q[0].d;
        void'(q.pop_front());
      end else begin
        check("o_data_hold", O_data, m_last);
      end
      if (O_de) obs.push_back(O_data);
    end
  end

  // one input cycle; tracks vsync pulses at frame level
  task automatic drive_raw(bit vs, bit de, logic [15:0] d);
    @(negedge I_pxl_clk);
    #1;
    I_rst  = 1'b0;
    I_vs_n = vs;
    I_de   = de;
    I_data = d;
    if (m_vs_prev && !vs) begin
      m_insync = 1'b1;
      m_active = 1'b0;
      m_short  = 1'b0;
    end else if (!m_vs_prev && vs && m_insync) begin
      m_insync = 1'b0;
      m_active = 1'b1;
      m_frame  = (m_frame + 1) % 65536;
      m_y      = 0;
    end
    m_vs_prev = vs;
  endtask

  task automatic do_reset(bit de, logic [15:0] d);
    @(negedge I_pxl_clk);
    #1;
    I_rst     = 1'b1;
    I_de      = de;
    I_data    = d;
    m_vs_prev = 1'b1;
    m_insync  = 1'b0;
    m_active  = 1'b0;
    m_y       = 0;
    m_frame   = 0;
    m_len     = 0;
    m_short   = 1'b0;
    m_last    = '0;
    q.delete();
  endtask

  task automatic pixel(int ln, int p, bit vs);
    logic [15:0] d;
    d = 16'(16 * ln + p);
    drive_raw(vs, 1'b1, d);
    if (m_active && p >= HS && p < HS + HO && m_y >= VS0 && m_y < VS0 + VO)
      q.push_back('{cyc + 2, d});
  endtask

  // n pixels of line ln; vsync drops at pixel abort_at when abort_at >= 0
  task automatic line(int ln, int n, int abort_at);
    bit ve;
    ve = 1'b1;
    for (int p = 0; p < n; p++) begin
      if (abort_at >= 0 && p >= abort_at) ve = 1'b0;
      pixel(ln, p, ve);
    end
    drive_raw(ve, 1'b0, '0);
    drive_raw(ve, 1'b0, '0);
    if (m_active) begin
      m_len = (n > 4095) ? 4095 : n;
      if (m_y >= VS0 && m_y < VS0 + VO && n < HS + HO) m_short = 1'b1;
      m_y++;
    end
  endtask

  task automatic vs_low(int k);
    repeat (k) drive_raw(1'b0, 1'b0, '0);
  endtask

  task automatic vs_high();
    drive_raw(1'b1, 1'b0, '0);
    drive_raw(1'b1, 1'b0, '0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_o_de"}, O_de, 1'b0);
    check({tag, "_o_data"}, O_data, 16'h0000);
    check({tag, "_o_vs_n"}, O_vs_n, 1'b1);
    check({tag, "_frame_cnt"}, O_frame_cnt, 16'd0);
    check({tag, "_line_len"}, O_line_len, 12'd0);
    check({tag, "_short_err"}, O_short_err, 1'b0);
  endtask

  task automatic check_obs(string tag, logic [15:0] exp[$]);
    logic [15:0] a;
    check({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      a = (i < obs.size()) ? obs[i] : 16'hDEAD;
      check({tag, "_pixel"}, a, exp[i]);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, "_frame_cnt"}, O_frame_cnt, 16'(m_frame));
    check({tag, "_line_len"}, O_line_len, 12'(m_len));
    check({tag, "_short_err"}, O_short_err, m_short);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(1'b0, '0);
    do_reset(1'b0, '0);
    run = 1'b1;
    drive_raw(1'b1, 1'b0, '0);
    check_reset_outputs("reset");

    // pixels before any vsync are never forwarded
    obs.delete();
    line(0, 8, -1);
    line(1, 8, -1);
    line(2, 8, -1);
    check("pre_vs_out_count", obs.size(), 0);
    check("pre_vs_frame_cnt", O_frame_cnt, 16'd0);
    check("pre_vs_line_len", O_line_len, 12'd0);

    // basic crop: lines 1 and 2, pixels 2..5
    vs_low(3);
    vs_high();
    check("f1_frame_cnt", O_frame_cnt, 16'd1);
    obs.delete();
    for (int ln = 0; ln < 4; ln++) line(ln, 8, -1);
    check_obs("f1_out", '{16'h12, 16'h13, 16'h14, 16'h15, 16'h22, 16'h23, 16'h24, 16'h25});
    check("f1_line_len", O_line_len, 12'd8);
    check("f1_short_err", O_short_err, 1'b0);
    check_model("f1");

    // short lines: outside window harmless, inside window sticky
    vs_low(2);
    vs_high();
    line(0, 3, -1);
    check("f2_l0_line_len", O_line_len, 12'd3);
    check("f2_l0_short_err", O_short_err, 1'b0);
    line(1, 8, -1);
    line(2, 5, -1);
    check("f2_l2_line_len", O_line_len, 12'd5);
    check("f2_l2_short_err", O_short_err, 1'b1);
    line(3, 8, -1);
    check("f2_sticky_short_err", O_short_err, 1'b1);
    check_model("f2");
    vs_low(2);
    check("vs_fall_clears_short_err", O_short_err, 1'b0);
    vs_high();
    check("f3_frame_cnt", O_frame_cnt, 16'd3);

    // vsync drops at pixel 3 of line 1
    obs.delete();
    line(0, 8, -1);
    line(1, 8, 3);
    check_obs("abort_out", '{16'h12});
    check("abort_line_len", O_line_len, 12'd8);
    vs_high();
    line(0, 8, -1);
    line(1, 8, -1);
    check_model("f4");

    // frame counter wrap
    vs_low(2);
    force dut.frame_cnt_q = 16'hFFFF;
    drive_raw(1'b0, 1'b0, '0);
    release dut.frame_cnt_q;
    m_frame = 65535;
    vs_high();
    check("wrap_frame_cnt", O_frame_cnt, 16'd0);
    check_model("wrap");

    // one-cycle reset in the middle of a kept line
    vs_low(2);
    vs_high();
    line(0, 8, -1);
    for (int p = 0; p < 4; p++) pixel(1, p, 1'b1);
    do_reset(1'b1, 16'h14);
    drive_raw(1'b1, 1'b1, 16'h15);
    check_reset_outputs("mid_reset");
    obs.delete();
    for (int p = 6; p < 8; p++) pixel(1, p, 1'b1);
    drive_raw(1'b1, 1'b0, '0);
    drive_raw(1'b1, 1'b0, '0);
    line(2, 8, -1);
    check("post_reset_out_count", obs.size(), 0);
    vs_low(2);
    vs_high();
    check("post_reset_frame_cnt", O_frame_cnt, 16'd1);

    // line longer than the counter range saturates
    line(0, 4100, -1);
    check("sat_line_len", O_line_len, 12'd4095);
    line(1, 8, -1);
    check_obs("post_reset_out", '{16'h12, 16'h13, 16'h14, 16'h15});
    check_model("final");

    repeat (4) drive_raw(1'b1, 1'b0, '0);
    run = 1'b0;
    check("expected_queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/video_crop_window.md
VIDEO_CROP_WINDOW -- requirements
Module: video_crop_window

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel width (RGB565).
REQ-002 SHALL have parameter H_START, default 0, first kept pixel index within an input line.
REQ-003 SHALL have parameter V_START, default 0, first kept line index within an input frame.
REQ-004 SHALL have parameter H_OUT, default 1280, kept pixels per line.
REQ-005 SHALL have parameter V_OUT, default 720, kept lines per frame.
REQ-006 SHALL have port I_pxl_clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port I_rst, input, 1, reset; synchronous and active-high.
REQ-008 SHALL have port I_vs_n, input, 1, camera vsync; negative polarity (low = sync).
REQ-009 SHALL have port I_de, input, 1, input pixel valid.
REQ-010 SHALL have port I_data, input, DATA_W, input pixel.
REQ-011 SHALL have port O_vs_n, output, 1, vsync to frame buffer, negative polarity.
REQ-012 SHALL have port O_de, output, 1, cropped pixel valid.
REQ-013 SHALL have port O_data, output, DATA_W, cropped pixel.
REQ-014 SHALL have port O_frame_cnt, output, 16, completed-sync counter.
REQ-015 SHALL have port O_line_len, output, 12, pixel count of the last finished input line.
REQ-016 SHALL have port O_short_err, output, 1, sticky per-frame short-line flag.

Function
REQ-017 SHALL run FSM states WAIT_VS -> IN_VS -> ACTIVE; WAIT_VS entered at reset.
REQ-018 SHALL transition WAIT_VS->IN_VS and ACTIVE->IN_VS on a registered falling edge of I_vs_n (1->0).
REQ-019 SHALL transition IN_VS->ACTIVE on a rising edge of I_vs_n; x and y counters cleared to 0 on this transition.
REQ-020 SHALL increment 12-bit x on every I_de=1 cycle in ACTIVE; saturate at 4095, no wrap.
REQ-021 SHALL, on I_de falling edge in ACTIVE, load O_line_len with x, clear x, increment 12-bit y (saturate at 4095).
REQ-022 SHALL qualify kept pixels as ACTIVE && I_de && H_START <= x < H_START+H_OUT && V_START <= y < V_START+V_OUT (x,y values before increment).
REQ-023 SHALL drive O_de/O_data exactly 2 cycles after the qualifying I_de/I_data; O_vs_n = I_vs_n delayed 2 cycles.
REQ-024 SHALL force O_de=0 in WAIT_VS and IN_VS; a partial frame after reset is never forwarded.
REQ-025 SHALL hold O_data at its last value when O_de=0.
REQ-026 SHALL increment O_frame_cnt by 1 on each IN_VS->ACTIVE transition, wrapping 65535->0.
REQ-027 SHALL set O_short_err when a line ends with V_START <= y < V_START+V_OUT and x < H_START+H_OUT; cleared on entry to IN_VS.
REQ-028 SHALL, on I_vs_n falling in mid-line (I_de=1), abandon the line: O_de=0 from that pixel on, no O_line_len update, no short-err check.
REQ-029 SHALL ignore I_de while in IN_VS (no counting, no output).
REQ-030 SHALL require H_START+H_OUT <= 4095 and V_START+V_OUT <= 4095; other values unsupported.

Reset
REQ-031 SHALL, while I_rst=1 at a clock edge, set state=WAIT_VS, x=y=0, O_de=0, O_data=0, O_vs_n=1, O_frame_cnt=0, O_line_len=0, O_short_err=0, edge-detect registers=1 (vs_n) / 0 (de), pipeline cleared.
REQ-032 SHALL, on reset asserted mid-frame, drop O_de within the same edge and resume only after the next complete I_vs_n low pulse.

Verification
REQ-033 Params H_START=2,V_START=1,H_OUT=4,V_OUT=2; reset, vsync pulse, 4 lines of 8 pixels (data = 16*line+pixel) -> O_de pulses of 4 on lines 1,2 carrying 0x12..0x15, 0x22..0x25, each 2 cycles after input; O_frame_cnt=1.
REQ-034 Pixels supplied before first vsync after reset -> O_de stays 0; O_frame_cnt=0.
REQ-035 Same params, line 2 only 5 pixels -> O_short_err=1, O_line_len=5; next vsync falling edge -> O_short_err=0.
REQ-036 I_vs_n falls at pixel 3 of line 1 -> O_de=0 from that pixel; O_line_len keeps previous value 8.
REQ-037 Preload 65535 frames (or force counter) then one vsync -> O_frame_cnt=0.
REQ-038 I_rst=1 for one cycle mid-line -> next edge all outputs at reset values; O_de returns only after full vsync pulse.
